reg_dump_unit: RTL and testbench



---
 rtl/debug_pkg.sv | 29 ++
 rtl/word_serializer.sv | 69 ++++++
 rtl/reg_dump_unit.sv | 98 +++++++++
 tb/tb_reg_dump_unit.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants and state encodings for the register-bank debug dump path.
package debug_pkg;

    localparam int unsigned BANK_SIZE      = 32;
    localparam int unsigned ADDR_LENGTH    = 5;
    localparam int unsigned DATA_LENGTH    = 32;
    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned BYTES_PER_WORD = DATA_LENGTH / BYTE_WIDTH;
    localparam int unsigned BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(BANK_SIZE - 1);
    localparam logic [BYTE_CNT_W-1:0]  LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } dump_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_WAIT
    } ser_state_e;

endpackage

// File: rtl/word_serializer.sv
// Shifts one captured register word out MSB-byte-first over a start/done byte handshake.
module word_serializer
    import debug_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   load,
    input  logic [DATA_LENGTH-1:0] word,
    output logic                   tx_start,
    output logic [BYTE_WIDTH-1:0]  tx_data,
    input  logic                   tx_done,
    output logic                   last_byte_done_c
);

    ser_state_e               phase_q, phase_d;
    logic [DATA_LENGTH-1:0]   shreg_q, shreg_d;
    logic [BYTE_CNT_W-1:0]    cnt_q, cnt_d;
    logic                     tx_start_q, tx_start_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q    <= SER_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
        end
    end

    // tx_done is only honoured in WAIT, so early or stray pulses never advance the byte.
    always_comb begin
        phase_d          = phase_q;
        shreg_d          = shreg_q;
        cnt_d            = cnt_q;
        last_byte_done_c = 1'b0;
        case (phase_q)
            SER_IDLE: begin
                if (load) begin
                    shreg_d = word;
                    cnt_d   = '0;
                    phase_d = SER_SEND;
                end
            end
            SER_SEND: phase_d = SER_WAIT;
            SER_WAIT: begin
                if (tx_done) begin
                    shreg_d = shreg_q << BYTE_WIDTH;
                    cnt_d   = cnt_q + BYTE_CNT_W'(1);
                    if (cnt_q == LAST_BYTE) begin
                        last_byte_done_c = 1'b1;
                        phase_d          = SER_IDLE;
                    end else begin
                        phase_d = SER_SEND;
                    end
                end
            end
            default: phase_d = SER_IDLE;
        endcase
        tx_start_d = (phase_d == SER_SEND);
    end

    assign tx_start = tx_start_q;
    assign tx_data  = shreg_q[DATA_LENGTH-1 -: BYTE_WIDTH];

endmodule

// File: rtl/reg_dump_unit.sv
// Walks the register bank on a debug request and streams every word out through the UART byte handshake.
module reg_dump_unit
    import debug_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic [ADDR_LENGTH-1:0] o_reg_addr,
    input  logic [DATA_LENGTH-1:0] i_reg_data,
    output logic [BYTE_WIDTH-1:0]  o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    dump_state_e              state_q, state_d;
    logic [ADDR_LENGTH-1:0]   addr_q, addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     load_c;
    logic                     last_byte_done_c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // SEND/WAIT mirror the serializer so NEXT follows the final byte ack with no dead cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_c  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (last_byte_done_c) begin
                    state_d = ST_NEXT;
                end else if (i_tx_done) begin
                    state_d = ST_SEND;
                end
            end
            ST_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_LENGTH'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    word_serializer u_word_serializer (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .load             (load_c),
        .word             (i_reg_data),
        .tx_start         (o_tx_start),
        .tx_data          (o_tx_data),
        .tx_done          (i_tx_done),
        .last_byte_done_c (last_byte_done_c)
    );

    assign o_reg_addr = addr_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: UART responder, bank model and expected byte stream.
module tb_reg_dump_unit;
    import debug_pkg::*;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic                   i_start;
    logic [ADDR_LENGTH-1:0] o_reg_addr;
    logic [DATA_LENGTH-1:0] i_reg_data;
    logic [BYTE_WIDTH-1:0]  o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done;
    logic                   o_busy;
    logic                   o_done;

    logic uart_done = 1'b0;
    logic spur_done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_LENGTH-1:0] bank [BANK_SIZE];
    logic [7:0] exp_q [$];

    int  uart_delay = 3;
    bit  rand_mode  = 1'b0;

    int  cyc = 0, n_tx = 0, n_done = 0, n_consec = 0;
    logic prev_start = 1'b0;
    logic [7:0] byte_q [$];
    int  baddr_q [$];

    reg_dump_unit dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (i_reg_data),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    assign i_reg_data = bank[o_reg_addr];
    assign i_tx_done  = uart_done | spur_done;

    // Observer: records every transmitted byte with its address, and done pulses.
    initial forever begin
        @(negedge i_clk);
        cyc++;
        if (o_tx_start) begin
            n_tx++;
            byte_q.push_back(o_tx_data);
            baddr_q.push_back(int'(o_reg_addr));
            if (prev_start) n_consec++;
        end
        prev_start = o_tx_start;
        if (o_done) n_done++;
    end

    // UART responder: raises done for one cycle, N cycles after the start pulse.
    initial begin
        int pending;
        pending = 0;
        forever begin
            @(negedge i_clk);
            uart_done = 1'b0;
            if (!i_rst_n) begin
                pending = 0;
            end else begin
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) uart_done = 1'b1;
                end
                if (o_tx_start) pending = rand_mode ? int'($urandom_range(1, 5)) : uart_delay;
            end
        end
    end

    function automatic void build_expected();
        exp_q.delete();
        for (int r = 0; r < int'(BANK_SIZE); r++)
            for (int b = int'(BYTES_PER_WORD) - 1; b >= 0; b--)
                exp_q.push_back(8'(bank[r] >> (b * 8)));
    endfunction

    function automatic int dump_cycles(input int n);
        return int'(BANK_SIZE) * (2 + int'(BYTES_PER_WORD) * (1 + n)) + 1;
    endfunction

    function automatic void fill_random();
        for (int r = 0; r < int'(BANK_SIZE); r++) bank[r] = $urandom;
    endfunction

    task automatic start_dump();
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge i_clk);
            if (o_done) begin
                dcyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        #12;
        vectors++;
        if ({o_reg_addr, o_tx_data, o_tx_start, o_busy, o_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%0d data=%h start=%b busy=%b done=%b, want all 0",
                     o_reg_addr, o_tx_data, o_tx_start, o_busy, o_done);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        vectors++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_done !== 1'b0 || n_tx != 0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b start=%b done=%b tx=%0d, want 0 0 0 0",
                     o_busy, o_tx_start, o_done, n_tx);
        end
    endtask

    task automatic test_full_dump();
        int base, nd0, d;
        for (int r = 0; r < int'(BANK_SIZE); r++) bank[r] = DATA_LENGTH'(r);
        bank[0]  = 32'h0;
        bank[1]  = 32'h1122_3344;
        bank[31] = 32'hDEAD_BEEF;
        build_expected();
        rand_mode = 1'b0;
        uart_delay = 3;
        base = n_tx;
        nd0 = n_done;
        start_dump();
        wait_done(5000, d);
        @(negedge i_clk);
        vectors++;
        if (d != dump_cycles(3)) begin
            miscompares++;
            $display("FAIL full_latency: got %0d cycles, want %0d", d, dump_cycles(3));
        end
        vectors++;
        if (n_tx - base != 128) begin
            miscompares++;
            $display("FAIL full_count: got %0d bytes, want 128", n_tx - base);
        end
        vectors++;
        if (n_done - nd0 != 1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done: got %0d done pulses busy=%b, want 1 pulse busy=0", n_done - nd0, o_busy);
        end
        if (n_tx - base == 128) begin
            logic [7:0] want_hi [8];
            want_hi = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
            for (int i = 0; i < 8; i++) begin
                int idx;
                idx = (i < 4) ? 4 + i : 120 + i;
                vectors++;
                if (byte_q[base + idx] !== want_hi[i]) begin
                    miscompares++;
                    $display("FAIL full_byte%0d: got %h, want %h", idx, byte_q[base + idx], want_hi[i]);
                end
            end
            for (int i = 0; i < 128; i++) begin
                vectors++;
                if (byte_q[base + i] !== exp_q[i] || baddr_q[base + i] != i / 4) begin
                    miscompares++;
                    $display("FAIL full_stream%0d: got %h@%0d, want %h@%0d",
                             i, byte_q[base + i], baddr_q[base + i], exp_q[i], i / 4);
                end
            end
        end
    endtask

    task automatic test_fast_uart();
        int base, c0, d;
        fill_random();
        build_expected();
        rand_mode = 1'b0;
        uart_delay = 1;
        base = n_tx;
        c0 = n_consec;
        start_dump();
        wait_done(5000, d);
        @(negedge i_clk);
        vectors++;
        if (d != dump_cycles(1) || d != 321) begin
            miscompares++;
            $display("FAIL fast_latency: got %0d cycles, want 321", d);
        end
        vectors++;
        if (n_consec != c0) begin
            miscompares++;
            $display("FAIL fast_back_to_back_start: got %0d adjacent starts, want 0", n_consec - c0);
        end
        vectors++;
        if (n_tx - base != 128) begin
            miscompares++;
            $display("FAIL fast_count: got %0d bytes, want 128", n_tx - base);
        end else begin
            for (int i = 0; i < 128; i++) begin
                vectors++;
                if (byte_q[base + i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL fast_stream%0d: got %h, want %h", i, byte_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_busy_start();
        int base, nd0, d, base2;
        fill_random();
        bank[0] = 32'hA5C3_0F96;
        build_expected();
        rand_mode = 1'b0;
        uart_delay = 2;
        base = n_tx;
        nd0 = n_done;
        start_dump();
        for (int k = 0; k < 5000; k++) begin
            @(posedge i_clk);
            if (n_tx - base >= 40) break;
        end
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(5000, d);
        vectors++;
        if (d < 0) begin
            miscompares++;
            $display("FAIL busy_timeout: got no done, want done");
        end
        start_dump();
        base2 = n_tx;
        vectors++;
        if (base2 - base != 128 || n_done - nd0 != 1) begin
            miscompares++;
            $display("FAIL busy_ignore: got %0d bytes %0d done, want 128 bytes 1 done",
                     base2 - base, n_done - nd0);
        end
        wait_done(5000, d);
        @(negedge i_clk);
        vectors++;
        if (d != dump_cycles(2) || n_tx - base2 != 128) begin
            miscompares++;
            $display("FAIL restart_after_done: got %0d cycles %0d bytes, want %0d cycles 128 bytes",
                     d, n_tx - base2, dump_cycles(2));
        end else begin
            vectors++;
            if (baddr_q[base2] != 0 || byte_q[base2] !== 8'hA5) begin
                miscompares++;
                $display("FAIL restart_first: got %h@%0d, want a5@0", byte_q[base2], baddr_q[base2]);
            end
            for (int i = 0; i < 128; i++) begin
                vectors++;
                if (byte_q[base2 + i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL restart_stream%0d: got %h, want %h", i, byte_q[base2 + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_spurious_done();
        int base, rel, d;
        fill_random();
        build_expected();
        rand_mode = 1'b0;
        uart_delay = 2;
        base = n_tx;
        spur_done = 1'b1;
        repeat (3) @(negedge i_clk);
        start_dump();
        rel = 0;
        d = -1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge i_clk);
            rel++;
            spur_done = o_tx_start || (rel == 1);
            if (o_done) begin
                d = rel;
                break;
            end
        end
        spur_done = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (d != dump_cycles(2)) begin
            miscompares++;
            $display("FAIL spur_latency: got %0d cycles, want %0d", d, dump_cycles(2));
        end
        vectors++;
        if (n_tx - base != 128) begin
            miscompares++;
            $display("FAIL spur_count: got %0d bytes, want 128", n_tx - base);
        end else begin
            for (int i = 0; i < 128; i++) begin
                vectors++;
                if (byte_q[base + i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL spur_stream%0d: got %h, want %h", i, byte_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int base, nd0, d;
        fill_random();
        rand_mode = 1'b0;
        uart_delay = 1;
        base = n_tx;
        nd0 = n_done;
        start_dump();
        for (int k = 0; k < 5000; k++) begin
            @(posedge i_clk);
            if (n_tx - base >= 50) break;
        end
        #3 i_rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_reg_addr, o_tx_data, o_tx_start, o_busy, o_done} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got addr=%0d data=%h start=%b busy=%b done=%b, want all 0",
                     o_reg_addr, o_tx_data, o_tx_start, o_busy, o_done);
        end
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        vectors++;
        if (n_done != nd0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_done: got %0d done busy=%b, want 0 done busy=0", n_done - nd0, o_busy);
        end
        bank[0] = 32'h0;
        build_expected();
        base = n_tx;
        start_dump();
        wait_done(5000, d);
        @(negedge i_clk);
        vectors++;
        if (d != dump_cycles(1) || n_tx - base != 128) begin
            miscompares++;
            $display("FAIL midreset_redo: got %0d cycles %0d bytes, want %0d cycles 128 bytes",
                     d, n_tx - base, dump_cycles(1));
        end else begin
            vectors++;
            if (byte_q[base] !== 8'h00 || baddr_q[base] != 0) begin
                miscompares++;
                $display("FAIL midreset_first: got %h@%0d, want 00@0", byte_q[base], baddr_q[base]);
            end
            for (int i = 0; i < 128; i++) begin
                vectors++;
                if (byte_q[base + i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL midreset_stream%0d: got %h, want %h", i, byte_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random_uart();
        int base, nd0, d;
        fill_random();
        build_expected();
        rand_mode = 1'b1;
        base = n_tx;
        nd0 = n_done;
        start_dump();
        wait_done(5000, d);
        @(negedge i_clk);
        rand_mode = 1'b0;
        vectors++;
        if (d < 0 || n_tx - base != 128 || n_done - nd0 != 1) begin
            miscompares++;
            $display("FAIL random_done: got cycles=%0d bytes=%0d done=%0d, want bytes=128 done=1",
                     d, n_tx - base, n_done - nd0);
        end else begin
            for (int i = 0; i < 128; i++) begin
                vectors++;
                if (byte_q[base + i] !== exp_q[i] || baddr_q[base + i] != i / 4) begin
                    miscompares++;
                    $display("FAIL random_stream%0d: got %h@%0d, want %h@%0d",
                             i, byte_q[base + i], baddr_q[base + i], exp_q[i], i / 4);
                end
            end
        end
    endtask

    initial begin
        for (int r = 0; r < int'(BANK_SIZE); r++) bank[r] = '0;
        test_reset();
        test_full_dump();
        test_fast_uart();
        test_busy_start();
        test_spurious_done();
        test_reset_mid_dump();
        test_random_uart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
